// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: register map indices, CTRL/STATUS bit positions and the CTRL register layout
package mmio_timer_pkg;
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_LOAD    = 3'd1;
  localparam logic [2:0] REG_COUNT   = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_CAPTURE = 3'd4;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IE    = 2;
  localparam int CTRL_PRESC = 8;
  localparam int ST_EXPIRED = 0;
  localparam int ST_RUNNING = 1;
  localparam int ST_CAPF    = 2;
  localparam int PRESC_MAX  = 16;
  // presc is stored at its widest legal size; only the low PRESC_W bits are ever written
  typedef struct packed {
    logic [PRESC_MAX-1:0] presc;
    logic                 ie;
    logic                 auto;
    logic                 en;
  } ctrl_t;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides clk by presc+1 while en, emitting a one-cycle tick
//   clk, reset (async active-low), en (count enable), clr (restart from 0),
//   presc (divisor-1), tick (one cycle every presc+1 enabled cycles)
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  assign tick  = en & (cnt_q == presc);
  assign cnt_d = (clr | tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with level irq and optional event capture
//   clk, reset (async active-low), we/cs/a/wd bus write, rd combinational read data,
//   irq = EXPIRED & IE, cap_in external event (only with MMIO_TIMER_CAPTURE_EN defined)
module mmio_timer import mmio_timer_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        cs,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
`ifdef MMIO_TIMER_CAPTURE_EN
  input  logic        cap_in,
`endif
  output logic        irq
);
  ctrl_t             ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  load_q, load_d, count_q, count_d, cap_val;
  logic              expired_q, expired_d, capf, tick, expire;
  logic [2:0]        idx;
  logic              wr_ctrl, wr_load, wr_count, wr_status;
  logic              unused_ok;
  assign idx       = a[4:2];
  assign wr_ctrl   = we & cs & (idx == REG_CTRL);
  assign wr_load   = we & cs & (idx == REG_LOAD);
  assign wr_count  = we & cs & (idx == REG_COUNT);
  assign wr_status = we & cs & (idx == REG_STATUS);
  assign unused_ok = ^{a[31:5], a[1:0], wd};
  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk  (clk),
    .reset(reset),
    .en   (ctrl_q.en),
    .clr  (wr_ctrl),
    .presc(ctrl_q.presc[PRESC_W-1:0]),
    .tick (tick)
  );
  assign expire = tick & (count_q == '0);
  // a software COUNT write overrides both decrement and reload on the same edge
  assign count_d = wr_count ? wd[WIDTH-1:0]
                 : !tick ? count_q
                 : (count_q != '0) ? count_q - 1'b1
                 : ctrl_q.auto ? load_q : count_q;
  assign load_d  = wr_load ? wd[WIDTH-1:0] : load_q;
  // a new expiry beats a same-edge W1C
  assign expired_d = expire | (expired_q & ~(wr_status & wd[ST_EXPIRED]));
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) ctrl_d = '{presc: PRESC_MAX'(wd[CTRL_PRESC +: PRESC_W]), ie: wd[CTRL_IE],
                           auto: wd[CTRL_AUTO], en: wd[CTRL_EN]};
    else if (expire & ~ctrl_q.auto) ctrl_d.en = 1'b0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
`ifdef MMIO_TIMER_CAPTURE_EN
  logic sync1_q, sync2_q, prev_q, capf_q, rise;
  logic [WIDTH-1:0] capture_q;
  assign rise    = sync2_q & ~prev_q;
  assign capf    = capf_q;
  assign cap_val = capture_q;
  // captures the pre-tick COUNT of the edge on which the synchronised rise is seen
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      capf_q    <= 1'b0;
      capture_q <= '0;
    end else begin
      sync1_q   <= cap_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      capf_q    <= rise | (capf_q & ~(wr_status & wd[ST_CAPF]));
      capture_q <= rise ? count_q : capture_q;
    end
`else
  assign capf    = 1'b0;
  assign cap_val = '0;
`endif
  logic [31:0] st_rd;
  always_comb begin
    st_rd = '0;
    st_rd[ST_EXPIRED] = expired_q;
    st_rd[ST_RUNNING] = ctrl_q.en;
    st_rd[ST_CAPF]    = capf;
  end
  assign rd = idx == REG_CTRL    ? (32'(ctrl_q.presc) << CTRL_PRESC) | {29'b0, ctrl_q.ie, ctrl_q.auto, ctrl_q.en}
            : idx == REG_LOAD    ? 32'(load_q)
            : idx == REG_COUNT   ? 32'(count_q)
            : idx == REG_STATUS  ? st_rd
            : idx == REG_CAPTURE ? 32'(cap_val)
            : 32'b0;
  assign irq = expired_q & ctrl_q.ie;
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed self-checking bench for mmio_timer
module tb_mmio_timer;
  logic        clk = 1'b0, reset = 1'b1, we = 1'b0, cs = 1'b0;
  logic [31:0] a = '0, wd = '0, rd;
  logic        irq;
`ifdef MMIO_TIMER_CAPTURE_EN
  logic        cap_in = 1'b0;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mmio_timer dut (
    .clk(clk), .reset(reset), .we(we), .cs(cs), .a(a), .wd(wd), .rd(rd),
`ifdef MMIO_TIMER_CAPTURE_EN
    .cap_in(cap_in),
`endif
    .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [31:0] ad, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; cs = 1'b1; a = ad; wd = d;
    @(posedge clk);
    #1 we = 1'b0; cs = 1'b0;
  endtask
  task automatic rchk(input string tag, input logic [31:0] ad, input logic [31:0] exp);
    a = ad;
    #1 chk(tag, rd, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #1 reset = 1'b0;
    step(2);
    for (int i = 0; i < 8; i++) rchk("rst_init", 32'(i * 4), 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk) reset = 1'b1;
    // reset mid-count
    wr(32'h04, 32'h7);
    wr(32'h08, 32'h5);
    wr(32'h00, 32'h7);
    step(1);
    rchk("mid_count", 32'h08, 32'h4);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) rchk("rst_mid", 32'(i * 4), 32'h0);
    chk("rst_mid_irq", {31'b0, irq}, 32'h0);
    step(2);
    @(negedge clk) reset = 1'b1;
    step(3);
    rchk("post_rst_count", 32'h08, 32'h0);
    rchk("post_rst_status", 32'h0C, 32'h0);
    // auto-reload with irq
    wr(32'h04, 32'h3);
    wr(32'h08, 32'h3);
    wr(32'h00, 32'h7);
    rchk("auto_c3", 32'h08, 32'h3);
    chk("auto_irq0", {31'b0, irq}, 32'h0);
    step(1); rchk("auto_c2", 32'h08, 32'h2);
    step(1); rchk("auto_c1", 32'h08, 32'h1);
    step(1); rchk("auto_c0", 32'h08, 32'h0);
    chk("auto_irq_pre", {31'b0, irq}, 32'h0);
    step(1); rchk("auto_reload", 32'h08, 32'h3);
    chk("auto_irq1", {31'b0, irq}, 32'h1);
    rchk("auto_status", 32'h0C, 32'h3);
    wr(32'h0C, 32'h1);
    chk("auto_irq_clr", {31'b0, irq}, 32'h0);
    rchk("auto_c_after", 32'h08, 32'h2);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'h1);
    // one-shot
    wr(32'h08, 32'h2);
    wr(32'h00, 32'h1);
    rchk("os_c2", 32'h08, 32'h2);
    step(1); rchk("os_c1", 32'h08, 32'h1);
    step(1); rchk("os_c0", 32'h08, 32'h0);
    step(1); rchk("os_status", 32'h0C, 32'h1);
    rchk("os_ctrl", 32'h00, 32'h0);
    chk("os_irq", {31'b0, irq}, 32'h0);
    step(3); rchk("os_hold", 32'h08, 32'h0);
    // prescaler
    wr(32'h0C, 32'h1);
    wr(32'h08, 32'h2);
    wr(32'h00, 32'h301);
    rchk("ps_ctrl", 32'h00, 32'h301);
    step(3); rchk("ps_e3", 32'h08, 32'h2);
    step(1); rchk("ps_e4", 32'h08, 32'h1);
    step(3); rchk("ps_e7", 32'h08, 32'h1);
    step(1); rchk("ps_e8", 32'h08, 32'h0);
    step(3); rchk("ps_e11", 32'h0C, 32'h2);
    step(1); rchk("ps_e12", 32'h0C, 32'h1);
    // W1C on expiry edge
    wr(32'h0C, 32'h1);
    wr(32'h08, 32'h1);
    wr(32'h00, 32'h1);
    step(1);
    wr(32'h0C, 32'h1);
    rchk("w1c_vs_set", 32'h0C, 32'h1);
    wr(32'h0C, 32'h1);
    rchk("w1c_clear", 32'h0C, 32'h0);
    // CTRL write re-enabling on expiry-stop edge
    wr(32'h08, 32'h1);
    wr(32'h00, 32'h1);
    step(1);
    wr(32'h00, 32'h1);
    rchk("ctrl_vs_stop", 32'h0C, 32'h3);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'h1);
    // COUNT write on tick edge
    wr(32'h08, 32'd20);
    wr(32'h00, 32'h1);
    step(1); rchk("cw_c19", 32'h08, 32'd19);
    wr(32'h08, 32'd9);
    rchk("cw_wins", 32'h08, 32'd9);
    step(1); rchk("cw_dec", 32'h08, 32'd8);
    wr(32'h00, 32'h0);
    rchk("cw_stop", 32'h08, 32'd7);
    // ignored writes
    @(negedge clk);
    we = 1'b1; cs = 1'b0; a = 32'h08; wd = 32'h55;
    @(posedge clk);
    #1 we = 1'b0;
    rchk("cs0_ignored", 32'h08, 32'd7);
    wr(32'h14, 32'hDEAD);
    rchk("reg5_zero", 32'h14, 32'h0);
    wr(32'h10, 32'h1234);
    rchk("cap_ro", 32'h10, 32'h0);
    wr(32'h18, 32'h99);
    rchk("reg6_count", 32'h08, 32'd7);
    // LOAD at full width, auto-reload to max
    wr(32'h04, 32'hFFFF_FFFF);
    rchk("load_max", 32'h04, 32'hFFFF_FFFF);
    wr(32'h08, 32'h0);
    wr(32'h00, 32'h3);
    step(1); rchk("reload_max", 32'h08, 32'hFFFF_FFFF);
    step(1); rchk("max_dec", 32'h08, 32'hFFFF_FFFE);
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'h7);
    // capture
    wr(32'h08, 32'h40);
    wr(32'h00, 32'h1);
`ifdef MMIO_TIMER_CAPTURE_EN
    cap_in = 1'b1;
    step(1); cap_in = 1'b0;
    step(1); rchk("cap_early", 32'h10, 32'h0);
    step(1); rchk("cap_val", 32'h10, 32'h3E);
    rchk("cap_flag", 32'h0C, 32'h6);
    wr(32'h0C, 32'h4);
    rchk("capf_clr", 32'h0C, 32'h2);
`else
    step(3);
    rchk("cap_none", 32'h10, 32'h0);
    rchk("capf_none", 32'h0C, 32'h2);
`endif
    wr(32'h00, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
